// File: rtl/icache_nb_prefetch.sv
// Non-blocking set-associative instruction cache with sequential next-line prefetch,
// an unissued-request FIFO, and a tagged outstanding-miss table accepting out-of-order fills.
module icache_nb_prefetch #(
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = 8,
  parameter int NUM_PREFETCH    = 2,
  parameter int QUEUE_DEPTH     = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] proc2Icache_addr,
  input  logic        proc2Icache_redirect,
  output logic [63:0] Icache_data_out,
  output logic        Icache_valid_out,
  output logic [1:0]  proc2Imem_command,
  output logic [63:0] proc2Imem_addr,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag
);
  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = 29 - SET_BITS;
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int QP_BITS  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QC_BITS  = $clog2(QUEUE_DEPTH + 1);
  localparam int M_BITS   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic [NUM_WAYS-1:0] way_vld_q  [NUM_SETS];
  logic [TAG_BITS-1:0] way_tag_q  [NUM_SETS][NUM_WAYS];
  logic [63:0]         way_data_q [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0] rr_q       [NUM_SETS];

  logic [28:0]         q_line_q [QUEUE_DEPTH];
  logic [QP_BITS-1:0]  head_q, tail_q;
  logic [QC_BITS-1:0]  count_q;

  logic [MAX_OUTSTANDING-1:0] m_vld_q;
  logic [28:0]         m_line_q [MAX_OUTSTANDING];
  logic [3:0]          m_tag_q  [MAX_OUTSTANDING];

  logic [63:0]         last_addr_q;

  function automatic logic cache_hit(input logic [28:0] line);
    logic [SET_BITS-1:0] s;
    s = line[SET_BITS-1:0];
    cache_hit = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (way_vld_q[s][w] && (way_tag_q[s][w] == line[28:SET_BITS])) cache_hit = 1'b1;
  endfunction

  function automatic logic in_mshr(input logic [28:0] line);
    in_mshr = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if (m_vld_q[i] && (m_line_q[i] == line)) in_mshr = 1'b1;
  endfunction

  function automatic logic in_queue(input logic [28:0] line);
    logic [QP_BITS-1:0] p;
    in_queue = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      p = head_q + QP_BITS'(i);
      if ((QC_BITS'(i) < count_q) && (q_line_q[p] == line)) in_queue = 1'b1;
    end
  endfunction

  logic [28:0]          req_line;
  logic [SET_BITS-1:0]  req_set;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 changed;
  logic                 hit;
  logic [63:0]          hit_data;

  assign req_line = proc2Icache_addr[31:3];
  assign req_set  = req_line[SET_BITS-1:0];
  assign req_tag  = req_line[28:SET_BITS];
  assign changed  = (proc2Icache_addr != last_addr_q) | proc2Icache_redirect;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (way_vld_q[req_set][w] && (way_tag_q[req_set][w] == req_tag)) begin
        hit      = 1'b1;
        hit_data = way_data_q[req_set][w];
      end
  end

  // Enqueue candidates: a redirect empties the queue before this cycle's enqueues land.
  logic [NUM_PREFETCH:0] enq_vld;
  logic [28:0]           enq_line [NUM_PREFETCH+1];
  logic [QP_BITS-1:0]    enq_pos  [NUM_PREFETCH+1];
  logic [QC_BITS-1:0]    enq_cnt;
  logic [QC_BITS-1:0]    base_count;
  logic [QP_BITS-1:0]    base_tail;

  always_comb begin
    base_count = proc2Icache_redirect ? '0 : count_q;
    base_tail  = proc2Icache_redirect ? '0 : tail_q;
    enq_cnt    = '0;
    enq_vld    = '0;
    for (int c = 0; c <= NUM_PREFETCH; c++) begin
      enq_line[c] = req_line + 29'(c);
      enq_pos[c]  = base_tail + QP_BITS'(enq_cnt);
      enq_vld[c]  = changed && !cache_hit(enq_line[c])
                    && !(!proc2Icache_redirect && in_queue(enq_line[c]))
                    && !in_mshr(enq_line[c])
                    && (({1'b0, base_count} + {1'b0, enq_cnt}) < (QC_BITS+1)'(QUEUE_DEPTH));
      enq_cnt     = enq_cnt + QC_BITS'(enq_vld[c]);
    end
  end

  logic [28:0]         head_line;
  logic                free_found;
  logic [M_BITS-1:0]   free_idx;
  logic                pop, issue, alloc;

  assign head_line = q_line_q[head_q];

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
      if (!m_vld_q[i]) begin
        free_found = 1'b1;
        free_idx   = M_BITS'(i);
      end
    pop   = 1'b0;
    issue = 1'b0;
    if (count_q != '0) begin
      if (cache_hit(head_line) || in_mshr(head_line)) begin
        pop = 1'b1;
      end else if (free_found) begin
        issue = 1'b1;
        pop   = (Imem2proc_response != 4'd0);
      end
    end
    alloc = issue && (Imem2proc_response != 4'd0);
  end

  logic                fill_hit;
  logic [M_BITS-1:0]   fill_idx;
  logic [28:0]         fill_line;
  logic [SET_BITS-1:0] fill_set;
  logic                vic_free;
  logic [WAY_BITS-1:0] vic_way;

  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--)
      if ((Imem2proc_tag != 4'd0) && m_vld_q[i] && (m_tag_q[i] == Imem2proc_tag)) begin
        fill_hit = 1'b1;
        fill_idx = M_BITS'(i);
      end
    fill_line = m_line_q[fill_idx];
    fill_set  = fill_line[SET_BITS-1:0];
    vic_free  = 1'b0;
    vic_way   = rr_q[fill_set];
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!way_vld_q[fill_set][w]) begin
        vic_free = 1'b1;
        vic_way  = WAY_BITS'(w);
      end
  end

  // Outputs are forced idle while reset is held, whatever the stale state says.
  assign Icache_valid_out  = reset & hit;
  assign Icache_data_out   = (reset && hit) ? hit_data : '0;
  assign proc2Imem_command = (reset && issue) ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = (reset && issue) ? {32'b0, head_line, 3'b000} : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        way_vld_q[s] <= '0;
        rr_q[s]      <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      m_vld_q     <= '0;
      last_addr_q <= '1;
    end else begin
      last_addr_q <= proc2Icache_addr;
      if (proc2Icache_redirect) begin
        head_q  <= '0;
        tail_q  <= QP_BITS'(enq_cnt);
        count_q <= enq_cnt;
      end else begin
        head_q  <= head_q + QP_BITS'(pop);
        tail_q  <= tail_q + QP_BITS'(enq_cnt);
        count_q <= count_q + enq_cnt - QC_BITS'(pop);
      end
      if (alloc) m_vld_q[free_idx] <= 1'b1;
      if (fill_hit) begin
        m_vld_q[fill_idx]            <= 1'b0;
        way_vld_q[fill_set][vic_way] <= 1'b1;
        if (!vic_free)
          rr_q[fill_set] <= (NUM_WAYS > 1) ? rr_q[fill_set] + WAY_BITS'(1) : '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c <= NUM_PREFETCH; c++)
      if (enq_vld[c]) q_line_q[enq_pos[c]] <= enq_line[c];
    if (alloc) begin
      m_line_q[free_idx] <= head_line;
      m_tag_q[free_idx]  <= Imem2proc_response;
    end
    if (fill_hit) begin
      way_tag_q[fill_set][vic_way]  <= fill_line[28:SET_BITS];
      way_data_q[fill_set][vic_way] <= Imem2proc_data;
    end
  end

endmodule

// File: tb/tb_icache_nb_prefetch.sv
// Directed bench for icache_nb_prefetch: cold miss, out-of-order fills, backpressure,
// redirect squash, round-robin eviction and reset while loads are outstanding.
module tb_icache_nb_prefetch;
  logic        clock;
  logic        reset;
  logic [63:0] addr;
  logic        redir;
  logic [63:0] dout;
  logic        vout;
  logic [1:0]  cmd;
  logic [63:0] maddr;
  logic [3:0]  resp;
  logic [63:0] mdata;
  logic [3:0]  mtag;

  int checks = 0;
  int errors = 0;

  icache_nb_prefetch dut (
    .clock               (clock),
    .reset               (reset),
    .proc2Icache_addr    (addr),
    .proc2Icache_redirect(redir),
    .Icache_data_out     (dout),
    .Icache_valid_out    (vout),
    .proc2Imem_command   (cmd),
    .proc2Imem_addr      (maddr),
    .Imem2proc_response  (resp),
    .Imem2proc_data      (mdata),
    .Imem2proc_tag       (mtag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Holds reset for two edges, then releases it; the caller is in the first post-reset cycle.
  task automatic apply_reset(input logic [63:0] a);
    reset = 1'b0; addr = a; redir = 1'b0; resp = 4'd0; mtag = 4'd0; mdata = '0;
    tick();
    tick();
    settle();
    chk("rst_cmd", {62'd0, cmd}, 64'd0);
    chk("rst_addr", maddr, 64'd0);
    chk("rst_valid", {63'd0, vout}, 64'd0);
    reset = 1'b1;
  endtask

  // Brings one line (plus its two prefetch lines) into the cache, demand data d.
  task automatic load_line(input logic [63:0] a, input logic [63:0] d);
    addr = a; resp = 4'd0; mtag = 4'd0;
    tick();
    resp = 4'd1; settle();
    chk("evict_issue_addr", maddr, a);
    tick();
    resp = 4'd2; tick();
    resp = 4'd3; tick();
    resp = 4'd0; mtag = 4'd1; mdata = d; tick();
    mtag = 4'd2; mdata = 64'd0; tick();
    mtag = 4'd3; tick();
    mtag = 4'd0;
  endtask

  initial begin
    reset = 1'b0; addr = '0; redir = 1'b0; resp = '0; mdata = '0; mtag = '0;

    // Cold miss with two prefetches
    apply_reset(64'h100);
    settle();
    chk("cold_A_cmd", {62'd0, cmd}, 64'd0);
    chk("cold_A_valid", {63'd0, vout}, 64'd0);
    tick();
    resp = 4'd1; settle();
    chk("cold_B_cmd", {62'd0, cmd}, 64'd1);
    chk("cold_B_addr", maddr, 64'h100);
    tick();
    resp = 4'd2; settle();
    chk("cold_C_addr", maddr, 64'h108);
    tick();
    resp = 4'd3; settle();
    chk("cold_D_addr", maddr, 64'h110);
    tick();
    resp = 4'd0; mtag = 4'd1; mdata = 64'hDEAD; settle();
    chk("cold_E_cmd", {62'd0, cmd}, 64'd0);
    chk("cold_E_nobypass", {63'd0, vout}, 64'd0);
    tick();
    mtag = 4'd0; settle();
    chk("cold_F_valid", {63'd0, vout}, 64'd1);
    chk("cold_F_data", dout, 64'hDEAD);
    tick();

    // Out-of-order fills 3,1,2
    apply_reset(64'h100);
    tick();
    resp = 4'd1; tick();
    resp = 4'd2; tick();
    resp = 4'd3; tick();
    resp = 4'd0; mtag = 4'd3; mdata = 64'h3333; tick();
    mtag = 4'd1; mdata = 64'h1111; settle();
    chk("ooo_F_nobypass", {63'd0, vout}, 64'd0);
    tick();
    mtag = 4'd2; mdata = 64'h2222; settle();
    chk("ooo_G_data100", dout, 64'h1111);
    tick();
    mtag = 4'd0; settle();
    chk("ooo_H_valid100", {63'd0, vout}, 64'd1);
    chk("ooo_H_cmd", {62'd0, cmd}, 64'd0);
    tick();
    addr = 64'h108; settle();
    chk("ooo_I_data108", dout, 64'h2222);
    chk("ooo_I_cmd", {62'd0, cmd}, 64'd0);
    tick();
    addr = 64'h110; resp = 4'd5; settle();
    chk("ooo_J_data110", dout, 64'h3333);
    chk("ooo_J_issue", maddr, 64'h118);
    tick();
    resp = 4'd0; settle();
    chk("ooo_K_issue", maddr, 64'h120);
    tick();
    mtag = 4'd5; mdata = 64'h5555; tick();
    mtag = 4'd0; addr = 64'h118; settle();
    chk("ooo_M_valid118", {63'd0, vout}, 64'd1);
    chk("ooo_M_data118", dout, 64'h5555);
    tick();

    // Backpressure: five rejects, then accept
    apply_reset(64'h200);
    tick();
    for (int i = 0; i < 5; i++) begin
      resp = 4'd0; settle();
      chk("bp_hold_cmd", {62'd0, cmd}, 64'd1);
      chk("bp_hold_addr", maddr, 64'h200);
      tick();
    end
    resp = 4'd4; settle();
    chk("bp_accept_addr", maddr, 64'h200);
    tick();
    resp = 4'd0; settle();
    chk("bp_next_addr", maddr, 64'h208);
    tick();

    // Redirect squashes queued lines while the MSHR is full
    apply_reset(64'h400);
    tick();
    resp = 4'd1; settle();
    chk("rd_B_addr", maddr, 64'h400);
    tick();
    resp = 4'd2; settle();
    chk("rd_C_addr", maddr, 64'h408);
    tick();
    resp = 4'd3; addr = 64'h500; settle();
    chk("rd_D_addr", maddr, 64'h410);
    tick();
    resp = 4'd4; addr = 64'h600; settle();
    chk("rd_E_addr", maddr, 64'h500);
    tick();
    resp = 4'd0; addr = 64'h700; settle();
    chk("rd_F_full_cmd", {62'd0, cmd}, 64'd0);
    tick();
    redir = 1'b1; addr = 64'h800; settle();
    chk("rd_G_cmd", {62'd0, cmd}, 64'd0);
    tick();
    redir = 1'b0; mtag = 4'd2; mdata = 64'hAAAA; settle();
    chk("rd_H_cmd", {62'd0, cmd}, 64'd0);
    tick();
    mtag = 4'd0; resp = 4'd5; settle();
    chk("rd_I_cmd", {62'd0, cmd}, 64'd1);
    chk("rd_I_addr", maddr, 64'h800);
    tick();
    resp = 4'd0; addr = 64'h408; mtag = 4'd1; mdata = 64'hBBBB; settle();
    chk("rd_J_oldfill_data", dout, 64'hAAAA);
    chk("rd_J_full_cmd", {62'd0, cmd}, 64'd0);
    tick();
    mtag = 4'd0; addr = 64'h400; settle();
    chk("rd_K_oldfill_valid", {63'd0, vout}, 64'd1);
    chk("rd_K_oldfill_data", dout, 64'hBBBB);
    chk("rd_K_addr", maddr, 64'h808);
    tick();

    // Six lines into set 0: fifth evicts way 0, sixth evicts way 1
    apply_reset(64'h0);
    load_line(64'h000, 64'hE0);
    load_line(64'h040, 64'hE1);
    load_line(64'h080, 64'hE2);
    load_line(64'h0C0, 64'hE3);
    load_line(64'h100, 64'hE4);
    load_line(64'h140, 64'hE5);
    addr = 64'h000; settle();
    chk("ev_line0_valid", {63'd0, vout}, 64'd0);
    chk("ev_line0_data", dout, 64'd0);
    tick();
    addr = 64'h040; settle();
    chk("ev_line8_valid", {63'd0, vout}, 64'd0);
    tick();
    addr = 64'h080; settle();
    chk("ev_w2_data", dout, 64'hE2);
    tick();
    addr = 64'h0C0; settle();
    chk("ev_w3_data", dout, 64'hE3);
    tick();
    addr = 64'h100; settle();
    chk("ev_5th_data", dout, 64'hE4);
    tick();
    addr = 64'h140; settle();
    chk("ev_6th_data", dout, 64'hE5);
    tick();

    // Reset with three loads outstanding and lines still queued
    apply_reset(64'h900);
    tick();
    resp = 4'd1; tick();
    resp = 4'd2; tick();
    resp = 4'd3; addr = 64'hA00; tick();
    resp = 4'd0; reset = 1'b0; settle();
    chk("mf_rst_cmd", {62'd0, cmd}, 64'd0);
    chk("mf_rst_addr", maddr, 64'd0);
    tick();
    reset = 1'b1; mtag = 4'd1; mdata = 64'h5555; tick();
    mtag = 4'd2; tick();
    mtag = 4'd3; tick();
    mtag = 4'd0; addr = 64'h900; settle();
    chk("mf_900_valid", {63'd0, vout}, 64'd0);
    tick();
    addr = 64'h908; settle();
    chk("mf_908_valid", {63'd0, vout}, 64'd0);
    tick();
    addr = 64'h910; settle();
    chk("mf_910_valid", {63'd0, vout}, 64'd0);
    chk("mf_910_data", dout, 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
